// File: rtl/matmul_ctrl_pkg.sv
// Shared constants and types for the matmul launch controller.
// Holds the register map, the CTRL/STATUS bit positions, the ID word and the job record.
package matmul_ctrl_pkg;

  localparam logic [3:0] REG_ID         = 4'd0;
  localparam logic [3:0] REG_CTRL       = 4'd1;
  localparam logic [3:0] REG_STATUS     = 4'd2;
  localparam logic [3:0] REG_JOB_PUSH   = 4'd3;
  localparam logic [3:0] REG_DONE_COUNT = 4'd4;
  localparam logic [3:0] REG_LAST_DONE  = 4'd5;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_SRST_LSB   = 8;

  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_BUSY_LSB  = 8;
  localparam int STATUS_FULL_BIT  = 16;
  localparam int STATUS_EMPTY_BIT = 17;
  localparam int STATUS_OVF_BIT   = 18;

  localparam logic [31:0] ID_MAGIC = 32'h4D4D_0002;

  // The tag sits in the upper half so a JOB_PUSH write maps onto the struct directly.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] arg;
  } job_t;

endpackage

// File: rtl/matmul_job_fifo.sv
// Job queue: DEPTH entries of job_t with a synchronous flush and an occupancy count.
// A push into a full queue is accepted when a pop happens in the same cycle.
module matmul_job_fifo
  import matmul_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  job_t        push_data_i,
  input  logic        pop_i,
  output job_t        pop_data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  job_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/matmul_launch_ctrl.sv
// MMIO-programmed launcher: queues jobs and dispatches them round-robin to matmul engines,
// tracking per-engine busy state, completions and soft resets.
module matmul_launch_ctrl
  import matmul_ctrl_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int QDEPTH    = 8
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [3:0]              avmm_mmio_address,
  input  logic [63:0]             avmm_mmio_writedata,
  input  logic [7:0]              avmm_mmio_byteenable,
  input  logic                    avmm_mmio_write,
  input  logic                    avmm_mmio_read,
  output logic [63:0]             avmm_mmio_readdata,
  output logic                    avmm_mmio_readdatavalid,
  output logic                    avmm_mmio_waitrequest,
  output logic [NUM_UNITS-1:0]    unit_start,
  output logic [32*NUM_UNITS-1:0] unit_arg,
  input  logic [NUM_UNITS-1:0]    unit_ready,
  input  logic [NUM_UNITS-1:0]    unit_done,
  output logic [NUM_UNITS-1:0]    unit_reset
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                 wr_ok, ctrl_wr, flush, push, dispatch;
  logic                 ovf_set, ovf_clr, cnt_clr, grant_found;
  logic [NUM_UNITS-1:0] srst, free, done_acc, grant;
  logic [IW-1:0]        grant_idx, done_idx;
  logic [31:0]          done_n;
  job_t                 head_job;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;

  logic                 enable_q, enable_d, ovf_q, ovf_d, rvalid_q;
  logic [NUM_UNITS-1:0] busy_q, busy_d, start_q, ureset_q;
  logic [IW-1:0]        rr_q, rr_d;
  logic [31:0]          done_cnt_q, done_cnt_d;
  logic [63:0]          last_done_q, last_done_d, rdata_q, rdata_d;
  logic [31:0]          arg_q [NUM_UNITS];
  logic [31:0]          arg_d [NUM_UNITS];
  logic [31:0]          tag_q [NUM_UNITS];
  logic [31:0]          tag_d [NUM_UNITS];

  assign wr_ok    = avmm_mmio_write && (avmm_mmio_byteenable == 8'hFF);
  assign ctrl_wr  = wr_ok && (avmm_mmio_address == REG_CTRL);
  assign flush    = ctrl_wr && avmm_mmio_writedata[CTRL_FLUSH_BIT];
  assign srst     = ctrl_wr ? avmm_mmio_writedata[CTRL_SRST_LSB +: NUM_UNITS] : '0;
  assign push     = wr_ok && (avmm_mmio_address == REG_JOB_PUSH);
  assign cnt_clr  = wr_ok && (avmm_mmio_address == REG_DONE_COUNT);
  assign ovf_clr  = wr_ok && (avmm_mmio_address == REG_STATUS)
                    && avmm_mmio_writedata[STATUS_OVF_BIT];

  // Handshake: an engine takes a job on a unit_start pulse only while its unit_ready is high and
  // it is not already busy; it hands completion back with a single unit_done pulse.
  // An engine being soft-reset this cycle is neither free nor able to complete.
  assign free     = unit_ready & ~busy_q & ~srst;
  assign done_acc = unit_done & busy_q & ~srst;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!grant_found && free[(int'(rr_q) + k) % NUM_UNITS]) begin
        grant_found = 1'b1;
        grant_idx   = IW'((int'(rr_q) + k) % NUM_UNITS);
      end
    end
  end

  assign dispatch = enable_q && !fifo_empty && grant_found && !flush;
  assign ovf_set  = push && fifo_full && !dispatch && !flush;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_UNITS; i++) grant[i] = dispatch && (grant_idx == IW'(i));
  end

  // Walk downwards so the lowest accepted index is the one recorded.
  always_comb begin
    done_n   = '0;
    done_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (done_acc[i]) begin
        done_n   = done_n + 32'd1;
        done_idx = IW'(i);
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    if (ctrl_wr) enable_d = avmm_mmio_writedata[CTRL_ENABLE_BIT];
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    busy_d      = (busy_q & ~done_acc & ~srst) | grant;
    rr_d        = dispatch ? IW'((int'(grant_idx) + 1) % NUM_UNITS) : rr_q;
    done_cnt_d  = cnt_clr ? done_n : done_cnt_q + done_n;
    last_done_d = last_done_q;
    if (|done_acc) last_done_d = {29'b0, 3'(done_idx), tag_q[done_idx]};
    arg_d = arg_q;
    tag_d = tag_q;
    if (dispatch) begin
      arg_d[grant_idx] = head_job.arg;
      tag_d[grant_idx] = head_job.tag;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (avmm_mmio_address)
      REG_ID:         rdata_d = {ID_MAGIC, 16'(NUM_UNITS), 16'(QDEPTH)};
      REG_CTRL:       rdata_d[CTRL_ENABLE_BIT] = enable_q;
      REG_STATUS: begin
        rdata_d[STATUS_COUNT_LSB +: 7] = 7'(fifo_count);
        rdata_d[STATUS_BUSY_LSB +: 8]  = 8'(busy_q);
        rdata_d[STATUS_FULL_BIT]       = fifo_full;
        rdata_d[STATUS_EMPTY_BIT]      = fifo_empty;
        rdata_d[STATUS_OVF_BIT]        = ovf_q;
      end
      REG_DONE_COUNT: rdata_d[31:0] = done_cnt_q;
      REG_LAST_DONE:  rdata_d = last_done_q;
      default:        rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable_q    <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= '0;
      rr_q        <= '0;
      done_cnt_q  <= '0;
      last_done_q <= '0;
      start_q     <= '0;
      ureset_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        arg_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      enable_q    <= enable_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      done_cnt_q  <= done_cnt_d;
      last_done_q <= last_done_d;
      start_q     <= grant;
      ureset_q    <= srst;
      rdata_q     <= avmm_mmio_read ? rdata_d : '0;
      rvalid_q    <= avmm_mmio_read;
      arg_q       <= arg_d;
      tag_q       <= tag_d;
    end
  end

  matmul_job_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (job_t'(avmm_mmio_writedata)),
    .pop_i       (dispatch),
    .pop_data_o  (head_job),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) unit_arg[32*i +: 32] = arg_q[i];
  end

  assign unit_start              = start_q;
  assign unit_reset              = ureset_q;
  assign avmm_mmio_readdata      = rdata_q;
  assign avmm_mmio_readdatavalid = rvalid_q;
  assign avmm_mmio_waitrequest   = 1'b0;

endmodule

// File: tb/tb_matmul_launch_ctrl.sv
// Bench for matmul_launch_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based behavioural model.
module tb_matmul_launch_ctrl;

  localparam int NU = 4;
  localparam int QD = 8;

  logic            clk_clk, reset_reset_n;
  logic [3:0]      avmm_mmio_address;
  logic [63:0]     avmm_mmio_writedata;
  logic [7:0]      avmm_mmio_byteenable;
  logic            avmm_mmio_write, avmm_mmio_read;
  logic [63:0]     avmm_mmio_readdata;
  logic            avmm_mmio_readdatavalid, avmm_mmio_waitrequest;
  logic [NU-1:0]   unit_start, unit_ready, unit_done, unit_reset;
  logic [32*NU-1:0] unit_arg;

  matmul_launch_ctrl #(.NUM_UNITS(NU), .QDEPTH(QD)) dut (
    .clk_clk                 (clk_clk),
    .reset_reset_n           (reset_reset_n),
    .avmm_mmio_address       (avmm_mmio_address),
    .avmm_mmio_writedata     (avmm_mmio_writedata),
    .avmm_mmio_byteenable    (avmm_mmio_byteenable),
    .avmm_mmio_write         (avmm_mmio_write),
    .avmm_mmio_read          (avmm_mmio_read),
    .avmm_mmio_readdata      (avmm_mmio_readdata),
    .avmm_mmio_readdatavalid (avmm_mmio_readdatavalid),
    .avmm_mmio_waitrequest   (avmm_mmio_waitrequest),
    .unit_start              (unit_start),
    .unit_arg                (unit_arg),
    .unit_ready              (unit_ready),
    .unit_done               (unit_done),
    .unit_reset              (unit_reset)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0]   exp_q[$];
  bit            m_en, m_ovf;
  bit [NU-1:0]   m_busy;
  logic [31:0]   m_tag [NU];
  logic [31:0]   m_arg [NU];
  int            m_rr;
  logic [31:0]   m_cnt;
  logic [63:0]   m_last;
  logic [NU-1:0] exp_start, exp_reset;
  bit            exp_rvalid;
  logic [63:0]   exp_rdata;

  task automatic model_reset();
    exp_q.delete();
    m_en = 0; m_ovf = 0; m_busy = '0; m_rr = 0; m_cnt = '0; m_last = '0;
    for (int i = 0; i < NU; i++) begin m_tag[i] = '0; m_arg[i] = '0; end
    exp_start = '0; exp_reset = '0; exp_rvalid = 0; exp_rdata = '0;
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] a);
    logic [63:0] r;
    r = '0;
    case (a)
      4'd0: r = 64'h4D4D_0002_0004_0008;
      4'd1: r[0] = m_en;
      4'd2: begin
        r[6:0]     = 7'(exp_q.size());
        r[8 +: NU] = m_busy;
        r[16]      = (exp_q.size() == QD);
        r[17]      = (exp_q.size() == 0);
        r[18]      = m_ovf;
      end
      4'd4: r[31:0] = m_cnt;
      4'd5: r = m_last;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock edge worth of the model, evaluated from the inputs the DUT sampled.
  task automatic model_step();
    bit            wr, flush, push, ovf_set;
    logic [NU-1:0] srst, acc, nb;
    int            n, low, g, j;
    logic [63:0]   job;
    wr    = avmm_mmio_write && (avmm_mmio_byteenable == 8'hFF);
    flush = wr && avmm_mmio_address == 4'd1 && avmm_mmio_writedata[1];
    push  = wr && avmm_mmio_address == 4'd3;
    srst  = (wr && avmm_mmio_address == 4'd1) ? avmm_mmio_writedata[8 +: NU] : '0;
    exp_rvalid = avmm_mmio_read;
    exp_rdata  = avmm_mmio_read ? m_read(avmm_mmio_address) : '0;
    acc = unit_done & m_busy & ~srst;
    n = 0; low = -1;
    for (int i = 0; i < NU; i++) if (acc[i]) begin n++; if (low < 0) low = i; end
    if (wr && avmm_mmio_address == 4'd4) m_cnt = 32'(n);
    else m_cnt = m_cnt + 32'(n);
    if (low >= 0) m_last = {29'b0, 3'(low), m_tag[low]};
    nb = m_busy & ~acc & ~srst;
    exp_start = '0; g = -1;
    if (m_en && exp_q.size() > 0 && !flush)
      for (int k = 0; k < NU; k++) begin
        j = (m_rr + k) % NU;
        if (g < 0 && unit_ready[j] && !m_busy[j] && !srst[j]) g = j;
      end
    if (g >= 0) begin
      job = exp_q.pop_front();
      exp_start[g] = 1'b1;
      m_arg[g] = job[31:0];
      m_tag[g] = job[63:32];
      nb[g] = 1'b1;
      m_rr = (g + 1) % NU;
    end
    m_busy = nb;
    ovf_set = 0;
    if (flush) exp_q.delete();
    else if (push) begin
      if (exp_q.size() < QD) exp_q.push_back(avmm_mmio_writedata);
      else ovf_set = 1;
    end
    if (ovf_set) m_ovf = 1;
    else if (wr && avmm_mmio_address == 4'd2 && avmm_mmio_writedata[18]) m_ovf = 0;
    if (wr && avmm_mmio_address == 4'd1) m_en = avmm_mmio_writedata[0];
    exp_reset = srst;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk_clk) begin
    if (chk_en) begin
      logic [32*NU-1:0] ea;
      for (int i = 0; i < NU; i++) ea[32*i +: 32] = m_arg[i];
      check("unit_start", 128'(unit_start), 128'(exp_start));
      check("unit_reset", 128'(unit_reset), 128'(exp_reset));
      check("unit_arg", 128'(unit_arg), 128'(ea));
      check("readdatavalid", 128'(avmm_mmio_readdatavalid), 128'(exp_rvalid));
      check("waitrequest", 128'(avmm_mmio_waitrequest), 128'd0);
      if (exp_rvalid) check("readdata", 128'(avmm_mmio_readdata), 128'(exp_rdata));
    end
  end

  int cyc = 0;
  bit log_en = 0;
  int start_idx_q[$];
  int start_cyc_q[$];
  always @(negedge clk_clk) begin
    cyc++;
    if (log_en)
      for (int i = 0; i < NU; i++)
        if (unit_start[i]) begin start_idx_q.push_back(i); start_cyc_q.push_back(cyc); end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_clk);
    #1;
    model_step();
    @(negedge clk_clk);
  endtask

  task automatic idle();
    avmm_mmio_write = 0; avmm_mmio_read = 0; avmm_mmio_byteenable = 8'hFF;
    avmm_mmio_address = '0; avmm_mmio_writedata = '0; unit_done = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    idle();
    avmm_mmio_write = 1; avmm_mmio_address = a; avmm_mmio_writedata = d;
    tick();
    idle();
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [63:0] lit, input string nm);
    idle();
    avmm_mmio_read = 1; avmm_mmio_address = a;
    tick();
    check(nm, 128'(avmm_mmio_readdata), 128'(lit));
    idle();
  endtask

  task automatic pulse_done(input logic [NU-1:0] m);
    idle();
    unit_done = m;
    tick();
    idle();
  endtask

  task automatic do_reset();
    #2 reset_reset_n = 0;
    model_reset();
    idle();
    repeat (2) @(negedge clk_clk);
    #2 reset_reset_n = 1;
    @(negedge clk_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op, pdone, pen;
    reset_reset_n = 1;
    unit_ready = '1;
    idle();
    #3 reset_reset_n = 0;
    model_reset();
    chk_en = 1;
    repeat (2) @(negedge clk_clk);
    #2 reset_reset_n = 1;
    @(negedge clk_clk);

    read_lit(4'd0, 64'h4D4D_0002_0004_0008, "id");
    read_lit(4'd2, 64'h0000_0000_0002_0000, "status_after_reset");
    read_lit(4'd4, 64'h0, "done_count_after_reset");

    // Three jobs land on units 0,1,2 in consecutive cycles.
    wr(4'd1, 64'h1);
    log_en = 1;
    wr(4'd3, {32'd5, 32'h11});
    wr(4'd3, {32'd6, 32'h22});
    wr(4'd3, {32'd7, 32'h33});
    repeat (4) tick();
    log_en = 0;
    check("start_count", 128'(start_idx_q.size()), 128'd3);
    if (start_idx_q.size() == 3) begin
      check("start_order", 128'({start_idx_q[0], start_idx_q[1], start_idx_q[2]}),
            128'({32'd0, 32'd1, 32'd2}));
      check("start_consecutive", 128'({start_cyc_q[1] - start_cyc_q[0], start_cyc_q[2] - start_cyc_q[1]}),
            128'({32'd1, 32'd1}));
    end
    check("arg0", 128'(unit_arg[31:0]), 128'h11);
    check("arg1", 128'(unit_arg[63:32]), 128'h22);
    check("arg2", 128'(unit_arg[95:64]), 128'h33);

    // Simultaneous completion on units 0 and 2.
    pulse_done(4'b0101);
    read_lit(4'd4, 64'd2, "done_count_two");
    read_lit(4'd5, 64'h5, "last_done_unit0_tag5");
    read_lit(4'd2, 64'h0000_0000_0002_0200, "status_busy_unit1");

    // Soft reset of busy unit 1; its later done is not counted.
    wr(4'd1, 64'h201);
    check("unit_reset_pulse", 128'(unit_reset), 128'h2);
    read_lit(4'd2, 64'h0000_0000_0002_0000, "status_after_srst");
    pulse_done(4'b0010);
    read_lit(4'd4, 64'd2, "done_count_after_srst");

    // Overflow with the queue held.
    wr(4'd1, 64'h0);
    for (int i = 0; i < 9; i++) wr(4'd3, {32'(i), 32'(100 + i)});
    read_lit(4'd2, 64'h0000_0000_0005_0008, "status_full_ovf");
    wr(4'd2, 64'h4_0000);
    read_lit(4'd2, 64'h0000_0000_0001_0008, "status_ovf_cleared");

    // Push while full in the same cycle as a dispatch, then flush.
    unit_ready = '0;
    wr(4'd1, 64'h1);
    unit_ready = 4'b0001;
    wr(4'd3, {32'd9, 32'h99});
    unit_ready = '0;
    read_lit(4'd2, 64'h0000_0000_0001_0108, "status_push_pop_full");
    wr(4'd1, 64'h3);
    read_lit(4'd2, 64'h0000_0000_0002_0100, "status_after_flush");

    // Ignored writes.
    idle();
    avmm_mmio_write = 1; avmm_mmio_address = 4'd1; avmm_mmio_byteenable = 8'h7F;
    tick();
    idle();
    read_lit(4'd1, 64'h1, "partial_be_ignored");
    wr(4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    read_lit(4'd0, 64'h4D4D_0002_0004_0008, "id_ro");
    read_lit(4'd9, 64'h0, "unmapped_reads_zero");

    // Randomized traffic in three regimes, with a reset landing mid-flight after the first.
    for (int ph = 0; ph < 3; ph++) begin
      pdone = (ph == 0) ? 30 : (ph == 1) ? 5 : 60;
      pen   = (ph == 0) ? 90 : (ph == 1) ? 50 : 95;
      for (int c = 0; c < 700; c++) begin
        idle();
        for (int i = 0; i < NU; i++) begin
          unit_ready[i] = ($urandom_range(0, 99) < 75);
          unit_done[i]  = ($urandom_range(0, 99) < pdone);
        end
        avmm_mmio_address = 4'($urandom_range(0, 15));
        op = $urandom_range(0, 99);
        if (op < 45) begin
          avmm_mmio_write = 1; avmm_mmio_address = 4'd3;
          avmm_mmio_writedata = {$urandom, $urandom};
        end else if (op < 55) begin
          avmm_mmio_write = 1; avmm_mmio_address = 4'd1;
          avmm_mmio_writedata = '0;
          avmm_mmio_writedata[0] = ($urandom_range(0, 99) < pen);
          avmm_mmio_writedata[1] = ($urandom_range(0, 9) == 0);
          if ($urandom_range(0, 3) == 0) avmm_mmio_writedata[8 +: NU] = NU'($urandom);
        end else if (op < 60) begin
          avmm_mmio_write = 1; avmm_mmio_address = 4'd2;
          avmm_mmio_writedata = {$urandom, $urandom};
        end else if (op < 63) begin
          avmm_mmio_write = 1; avmm_mmio_address = 4'd4;
        end else if (op < 70) begin
          avmm_mmio_write = 1;
          avmm_mmio_writedata = {$urandom, $urandom};
          if ($urandom_range(0, 1) == 0) avmm_mmio_byteenable = 8'($urandom);
        end else if (op < 76) begin
          avmm_mmio_write = 1; avmm_mmio_address = 4'd3;
          avmm_mmio_writedata = {$urandom, $urandom};
          avmm_mmio_byteenable = 8'($urandom_range(0, 254));
        end
        avmm_mmio_read = ($urandom_range(0, 2) == 0);
        tick();
      end
      if (ph == 0) do_reset();
    end

    idle();
    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_launch_ctrl.md
MATMUL_LAUNCH_CTRL -- requirements
Module: matmul_launch_ctrl

Interface
REQ-001 Parameter NUM_UNITS, default 4, SHALL set the number of matmul engines served; legal range 1..8.
REQ-002 Parameter QDEPTH, default 8, SHALL set the job-queue depth; power of two, 2..64.
REQ-003 clk_clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset_reset_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 avmm_mmio_address  in  4  SHALL carry the 64-bit word index.
REQ-006 avmm_mmio_writedata / avmm_mmio_byteenable  in  64 / 8  SHALL carry write data and byte lanes.
REQ-007 avmm_mmio_write, avmm_mmio_read  in  1 each  SHALL carry access strobes.
REQ-008 avmm_mmio_readdata / avmm_mmio_readdatavalid / avmm_mmio_waitrequest  out  64 / 1 / 1  SHALL carry the read response; waitrequest tied 0.
REQ-009 unit_start  out  NUM_UNITS  SHALL carry a one-cycle start pulse per engine.
REQ-010 unit_arg  out  32*NUM_UNITS  SHALL carry the job argument per engine; slice i = bits [32i+31:32i].
REQ-011 unit_ready  in  NUM_UNITS  SHALL be high while engine i is able to accept a job.
REQ-012 unit_done  in  NUM_UNITS  SHALL carry a one-cycle completion pulse per engine.
REQ-013 unit_reset  out  NUM_UNITS  SHALL carry a one-cycle soft-reset pulse per engine.

Function
REQ-014 Register map (word index): 0 ID RO = {32'h4D4D_0002, 16'(NUM_UNITS), 16'(QDEPTH)}; 1 CTRL; 2 STATUS; 3 JOB_PUSH WO; 4 DONE_COUNT; 5 LAST_DONE RO; others read 0, writes ignored.
REQ-015 Writes with byteenable != 8'hFF SHALL be ignored everywhere.
REQ-016 Reads SHALL return data with readdatavalid exactly one cycle after read; reads have no side effects.
REQ-017 CTRL: bit0 enable (RW); bit1 flush (write-1 pulse); bits [8+NUM_UNITS-1:8] soft-reset (write-1 pulse); pulse bits read 0.
REQ-018 STATUS: [6:0] queue count; [15:8] busy mask; bit16 full; bit17 empty; bit18 overflow sticky, cleared by writing 1 to bit18 of word 2.
REQ-019 JOB_PUSH write SHALL enqueue {writedata[63:32] tag, writedata[31:0] arg}; when full and no pop that cycle, job dropped and overflow set.
REQ-020 Engine i is free when unit_ready[i]=1 and busy[i]=0.
REQ-021 Dispatch: when enable=1, queue non-empty and any engine free, SHALL pop one job, pulse unit_start[i] and load unit_arg slice i in the same registered cycle; at most one dispatch per cycle.
REQ-022 Engine selection SHALL be round-robin: search starts at index after last granted, wrapping at NUM_UNITS.
REQ-023 A job pushed in cycle t SHALL be dispatchable no earlier than cycle t+1.
REQ-024 unit_arg slice i SHALL hold until the next start to engine i.
REQ-025 busy[i] SHALL set with unit_start[i] and clear on unit_done[i]; done on a non-busy engine is ignored.
REQ-026 Each accepted done SHALL increment DONE_COUNT (32-bit, wraps) and set LAST_DONE = {29'b0, unit idx[2:0], tag[31:0]} for that job; simultaneous dones: lowest index recorded, count increments by popcount.
REQ-027 Any full-mask write to word 4 SHALL clear DONE_COUNT; a same-cycle done yields count = number of dones that cycle.
REQ-028 Flush SHALL empty the queue in one cycle; a same-cycle push is dropped without setting overflow; no dispatch that cycle.
REQ-029 Soft-reset bit i SHALL pulse unit_reset[i] one cycle later and clear busy[i]; same-cycle unit_done[i] is ignored.
REQ-030 Push and pop in the same cycle SHALL leave the count unchanged, including when full.
REQ-031 Clearing enable SHALL stop new dispatches; busy engines still complete and are counted.

Reset
REQ-032 On reset_reset_n low: queue empty, enable 0, busy 0, overflow 0, DONE_COUNT 0, LAST_DONE 0, round-robin pointer 0, all outputs 0.
REQ-033 Reset mid-job SHALL discard queued and in-flight jobs; subsequent dones are ignored.

Structure
REQ-034 Package matmul_ctrl_pkg SHALL hold register index constants, CTRL/STATUS bit positions, the ID constant and the job struct (tag, arg).
REQ-035 The queue SHALL be sub-module matmul_job_fifo (QDEPTH x 64, synchronous flush, count output).

Verification
REQ-036 Push args 0x11,0x22,0x33 with enable=1, all ready -> starts on units 0,1,2 in consecutive cycles, unit_arg slices 0x11/0x22/0x33.
REQ-037 NUM_UNITS=4, enable=0, push 9 jobs at QDEPTH=8 -> count 8, full=1, overflow=1; write STATUS bit18 -> overflow 0.
REQ-038 Units 0,2 done in same cycle, tags 5 and 7 -> DONE_COUNT +2, LAST_DONE idx 0 tag 5, busy bits cleared.
REQ-039 Unit 1 busy, write CTRL bit9 -> unit_reset[1] pulse, busy[1]=0, later unit_done[1] not counted.
REQ-040 Queue full, push and dispatch same cycle -> push accepted, count stays 8, no overflow; flush plus push -> count 0, overflow 0.
